// File: rtl/id_ex_forward_pipe_pkg.sv
// Shared constants for the ID/EX forwarding pipe: forward-select encodings,
// default widths and the bubble encoding of a tag stage.
package id_ex_forward_pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 4;
    localparam int CNT_W_DEF  = 16;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic BUBBLE_RF_EN = 1'b0;
    localparam logic BUBBLE_LD    = 1'b0;

endpackage

// File: rtl/id_ex_forward_pipe_tag_stage.sv
// One pipeline tag register {rd, rf_en, ld}: async reset to a bubble and a
// synchronous bubble input that overrides the incoming tag.
module id_ex_forward_pipe_tag_stage
    import id_ex_forward_pipe_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             bubble,
    input  logic [REG_W-1:0] rd_d,
    input  logic             rf_en_d,
    input  logic             ld_d,
    output logic [REG_W-1:0] rd_q,
    output logic             rf_en_q,
    output logic             ld_q
);

    logic [REG_W+1:0] tag_q;
    logic [REG_W+1:0] tag_bubble;

    assign tag_bubble = {{REG_W{1'b0}}, BUBBLE_RF_EN, BUBBLE_LD};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag_q <= tag_bubble;
        end else if (bubble) begin
            tag_q <= tag_bubble;
        end else begin
            tag_q <= {rd_d, rf_en_d, ld_d};
        end
    end

    assign rd_q    = tag_q[REG_W+1:2];
    assign rf_en_q = tag_q[1];
    assign ld_q    = tag_q[0];

endmodule

// File: rtl/id_ex_forward_pipe.sv
// ID/EX register with operand forwarding, bubble insertion for stall/flush,
// EX/MEM/WB destination-tag pipeline and a saturating bubble counter.
module id_ex_forward_pipe
    import id_ex_forward_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [1:0]        ISA,
    input  logic [1:0]        ISB,
    input  logic [1:0]        ISD,
    input  logic              C_Unit_MUX,
    input  logic              HZld,
    input  logic              flush,
    input  logic [DATA_W-1:0] rf_A_ID,
    input  logic [DATA_W-1:0] rf_B_ID,
    input  logic [DATA_W-1:0] rf_D_ID,
    input  logic [REG_W-1:0]  rd_ID,
    input  logic              rf_en_ID,
    input  logic              ld_ID,
    input  logic [DATA_W-1:0] res_EX,
    input  logic [DATA_W-1:0] res_MEM,
    input  logic [DATA_W-1:0] res_WB,
    input  logic              cnt_clr,
    output logic [DATA_W-1:0] opA_EX,
    output logic [DATA_W-1:0] opB_EX,
    output logic [DATA_W-1:0] opD_EX,
    output logic [REG_W-1:0]  RW_EX,
    output logic [REG_W-1:0]  RW_MEM,
    output logic [REG_W-1:0]  RW_WB,
    output logic              enable_RF_EX,
    output logic              enable_RF_MEM,
    output logic              enable_RF_WB,
    output logic              enable_LD_EX,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic bubble_ex;
    logic stall_cnt;
    logic ld_mem;
    logic ld_wb;
    logic unused_ld;

    // Flush and stall both bubble EX, but only a stall is a counted bubble.
    assign bubble_ex = flush | C_Unit_MUX | ~HZld;
    assign stall_cnt = ~flush & (C_Unit_MUX | ~HZld);

    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf_val,
        input logic [DATA_W-1:0] ex_val,
        input logic [DATA_W-1:0] mem_val,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] res;
        res = rf_val;
        case (sel)
            FWD_RF:  res = rf_val;
            FWD_EX:  res = ex_val;
            FWD_MEM: res = mem_val;
            FWD_WB:  res = wb_val;
            default: res = rf_val;
        endcase
        return res;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            opA_EX <= '0;
            opB_EX <= '0;
            opD_EX <= '0;
        end else if (bubble_ex) begin
            opA_EX <= '0;
            opB_EX <= '0;
            opD_EX <= '0;
        end else begin
            opA_EX <= fwd_mux(ISA, rf_A_ID, res_EX, res_MEM, res_WB);
            opB_EX <= fwd_mux(ISB, rf_B_ID, res_EX, res_MEM, res_WB);
            opD_EX <= fwd_mux(ISD, rf_D_ID, res_EX, res_MEM, res_WB);
        end
    end

    id_ex_forward_pipe_tag_stage #(.REG_W(REG_W)) u_tag_ex (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .bubble  (bubble_ex),
        .rd_d    (rd_ID),
        .rf_en_d (rf_en_ID),
        .ld_d    (ld_ID),
        .rd_q    (RW_EX),
        .rf_en_q (enable_RF_EX),
        .ld_q    (enable_LD_EX)
    );

    // MEM and WB never stall; the load flag stops at EX.
    id_ex_forward_pipe_tag_stage #(.REG_W(REG_W)) u_tag_mem (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .bubble  (1'b0),
        .rd_d    (RW_EX),
        .rf_en_d (enable_RF_EX),
        .ld_d    (1'b0),
        .rd_q    (RW_MEM),
        .rf_en_q (enable_RF_MEM),
        .ld_q    (ld_mem)
    );

    id_ex_forward_pipe_tag_stage #(.REG_W(REG_W)) u_tag_wb (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .bubble  (1'b0),
        .rd_d    (RW_MEM),
        .rf_en_d (enable_RF_MEM),
        .ld_d    (1'b0),
        .rd_q    (RW_WB),
        .rf_en_q (enable_RF_WB),
        .ld_q    (ld_wb)
    );

    assign unused_ld = ld_mem ^ ld_wb;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (stall_cnt && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_forward_pipe.sv
// Self-checking bench for id_ex_forward_pipe: vector table plus hand-written
// load-use, saturation and reset sequences, compared through a scoreboard queue.
module tb_id_ex_forward_pipe;

    localparam int DW = 32;
    localparam int RW = 4;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [1:0]    ISA, ISB, ISD;
    logic          C_Unit_MUX, HZld, flush, cnt_clr;
    logic [DW-1:0] rf_A_ID, rf_B_ID, rf_D_ID;
    logic [RW-1:0] rd_ID;
    logic          rf_en_ID, ld_ID;
    logic [DW-1:0] res_EX, res_MEM, res_WB;
    logic [DW-1:0] opA_EX, opB_EX, opD_EX;
    logic [RW-1:0] RW_EX, RW_MEM, RW_WB;
    logic          enable_RF_EX, enable_RF_MEM, enable_RF_WB, enable_LD_EX;
    logic [CW-1:0] bubble_cnt;

    always #5 CLK = ~CLK;

    id_ex_forward_pipe #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ISA(ISA), .ISB(ISB), .ISD(ISD),
        .C_Unit_MUX(C_Unit_MUX), .HZld(HZld), .flush(flush),
        .rf_A_ID(rf_A_ID), .rf_B_ID(rf_B_ID), .rf_D_ID(rf_D_ID),
        .rd_ID(rd_ID), .rf_en_ID(rf_en_ID), .ld_ID(ld_ID),
        .res_EX(res_EX), .res_MEM(res_MEM), .res_WB(res_WB),
        .cnt_clr(cnt_clr),
        .opA_EX(opA_EX), .opB_EX(opB_EX), .opD_EX(opD_EX),
        .RW_EX(RW_EX), .RW_MEM(RW_MEM), .RW_WB(RW_WB),
        .enable_RF_EX(enable_RF_EX), .enable_RF_MEM(enable_RF_MEM),
        .enable_RF_WB(enable_RF_WB), .enable_LD_EX(enable_LD_EX),
        .bubble_cnt(bubble_cnt)
    );

    typedef struct packed {
        logic [1:0]  isa, isb, isd;
        logic        cmux, hzld, flush, clr;
        logic [3:0]  rd;
        logic        rf_en, ld;
        logic [31:0] ea, eb, ed;
    } vec_t;

    typedef struct packed {
        logic [31:0] a, b, d;
        logic [3:0]  rw_ex, rw_mem, rw_wb;
        logic        en_ex, en_mem, en_wb, ld_ex;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0] m_ex_rd, m_mem_rd;
    logic       m_ex_en, m_mem_en;
    logic [3:0] m_cnt;

    function automatic vec_t mk(
        input logic [1:0] isa, input logic [1:0] isb, input logic [1:0] isd,
        input logic cmux, input logic hzld, input logic fl, input logic clr,
        input logic [3:0] rd, input logic rf_en, input logic ld,
        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ed
    );
        vec_t v;
        v.isa = isa; v.isb = isb; v.isd = isd;
        v.cmux = cmux; v.hzld = hzld; v.flush = fl; v.clr = clr;
        v.rd = rd; v.rf_en = rf_en; v.ld = ld;
        v.ea = ea; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        chk("opA_EX", opA_EX, e.a);
        chk("opB_EX", opB_EX, e.b);
        chk("opD_EX", opD_EX, e.d);
        chk("RW_EX", 32'(RW_EX), 32'(e.rw_ex));
        chk("RW_MEM", 32'(RW_MEM), 32'(e.rw_mem));
        chk("RW_WB", 32'(RW_WB), 32'(e.rw_wb));
        chk("enable_RF_EX", 32'(enable_RF_EX), 32'(e.en_ex));
        chk("enable_RF_MEM", 32'(enable_RF_MEM), 32'(e.en_mem));
        chk("enable_RF_WB", 32'(enable_RF_WB), 32'(e.en_wb));
        chk("enable_LD_EX", 32'(enable_LD_EX), 32'(e.ld_ex));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
    endtask

    task automatic model_reset();
        m_ex_rd = '0; m_ex_en = 1'b0; m_mem_rd = '0; m_mem_en = 1'b0; m_cnt = '0;
        sb.delete();
    endtask

    // Drive one ID-stage cycle, predict the post-edge outputs, then compare.
    task automatic apply(input vec_t v);
        exp_t e;
        logic bub;
        ISA = v.isa; ISB = v.isb; ISD = v.isd;
        C_Unit_MUX = v.cmux; HZld = v.hzld; flush = v.flush; cnt_clr = v.clr;
        rd_ID = v.rd; rf_en_ID = v.rf_en; ld_ID = v.ld;
        bub = v.flush | v.cmux | ~v.hzld;
        e.rw_wb  = m_mem_rd;
        e.en_wb  = m_mem_en;
        e.rw_mem = m_ex_rd;
        e.en_mem = m_ex_en;
        e.rw_ex  = bub ? 4'd0 : v.rd;
        e.en_ex  = bub ? 1'b0 : v.rf_en;
        e.ld_ex  = bub ? 1'b0 : v.ld;
        e.a      = bub ? 32'd0 : v.ea;
        e.b      = bub ? 32'd0 : v.eb;
        e.d      = bub ? 32'd0 : v.ed;
        if (v.clr) m_cnt = 4'd0;
        else if (!v.flush && (v.cmux || !v.hzld) && m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
        e.cnt = m_cnt;
        m_mem_rd = m_ex_rd; m_mem_en = m_ex_en;
        m_ex_rd = e.rw_ex;  m_ex_en = e.en_ex;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            check_all(sb.pop_front());
        end
    endtask

    vec_t vecs[12];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t z;
        z = '0;
        rf_A_ID = 32'h1; rf_B_ID = 32'h11; rf_D_ID = 32'h21;
        res_EX = 32'h2; res_MEM = 32'h3; res_WB = 32'h4;
        ISA = 2'b00; ISB = 2'b00; ISD = 2'b00;
        C_Unit_MUX = 1'b0; HZld = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        rd_ID = 4'd9; rf_en_ID = 1'b1; ld_ID = 1'b1;

        //          isa   isb   isd   cm hz fl clr rd    en ld  ea      eb      ed
        vecs[0]  = mk(2'd0, 2'd0, 2'd0, 0, 1, 0, 1, 4'd1,  1, 0, 32'h1,  32'h11, 32'h21);
        vecs[1]  = mk(2'd1, 2'd2, 2'd3, 0, 1, 0, 0, 4'd2,  1, 0, 32'h2,  32'h3,  32'h4);
        vecs[2]  = mk(2'd2, 2'd3, 2'd0, 0, 1, 0, 0, 4'd5,  1, 0, 32'h3,  32'h4,  32'h21);
        vecs[3]  = mk(2'd3, 2'd0, 2'd1, 0, 1, 0, 0, 4'd6,  0, 0, 32'h4,  32'h11, 32'h2);
        vecs[4]  = mk(2'd0, 2'd1, 2'd2, 0, 1, 0, 0, 4'd7,  1, 1, 32'h1,  32'h2,  32'h3);
        vecs[5]  = mk(2'd1, 2'd1, 2'd1, 1, 1, 0, 0, 4'd8,  1, 0, 32'h2,  32'h2,  32'h2);
        vecs[6]  = mk(2'd2, 2'd2, 2'd2, 0, 0, 0, 0, 4'd9,  1, 0, 32'h3,  32'h3,  32'h3);
        vecs[7]  = mk(2'd3, 2'd3, 2'd3, 0, 1, 1, 0, 4'd10, 1, 1, 32'h4,  32'h4,  32'h4);
        vecs[8]  = mk(2'd0, 2'd0, 2'd0, 1, 1, 1, 0, 4'd11, 1, 0, 32'h1,  32'h11, 32'h21);
        vecs[9]  = mk(2'd3, 2'd3, 2'd3, 0, 1, 0, 0, 4'd12, 1, 0, 32'h4,  32'h4,  32'h4);
        vecs[10] = mk(2'd0, 2'd0, 2'd0, 1, 1, 0, 1, 4'd13, 1, 0, 32'h1,  32'h11, 32'h21);
        vecs[11] = mk(2'd2, 2'd1, 2'd0, 0, 1, 0, 0, 4'd14, 1, 1, 32'h3,  32'h2,  32'h21);

        // Reset from power-up: outputs zero, and still zero after release before an edge.
        RST_N = 1'b0;
        #1;
        check_all(z);
        @(posedge CLK);
        #2 RST_N = 1'b1;
        #1;
        check_all(z);
        model_reset();

        for (int i = 0; i < 12; i++) apply(vecs[i]);

        // Tag flow of rd=5 through EX/MEM/WB with no stalls.
        apply(mk(2'd0, 2'd0, 2'd0, 0, 1, 0, 0, 4'd5, 1, 0, 32'h1, 32'h11, 32'h21));
        chk("flow_RW_EX", 32'(RW_EX), 32'd5);
        apply(mk(2'd0, 2'd0, 2'd0, 0, 1, 0, 0, 4'd1, 0, 0, 32'h1, 32'h11, 32'h21));
        chk("flow_RW_MEM", 32'(RW_MEM), 32'd5);
        apply(mk(2'd0, 2'd0, 2'd0, 0, 1, 0, 0, 4'd2, 0, 0, 32'h1, 32'h11, 32'h21));
        chk("flow_RW_WB", 32'(RW_WB), 32'd5);
        chk("flow_en_WB", 32'(enable_RF_WB), 32'd1);

        // Load-use: LDR R3, one stall cycle, consumer forwarded from MEM.
        apply(mk(2'd0, 2'd0, 2'd0, 0, 1, 0, 1, 4'd1, 1, 0, 32'h1, 32'h11, 32'h21));
        apply(mk(2'd0, 2'd0, 2'd0, 0, 1, 0, 0, 4'd3, 1, 1, 32'h1, 32'h11, 32'h21));
        chk("ldr_RW_EX", 32'(RW_EX), 32'd3);
        chk("ldr_LD_EX", 32'(enable_LD_EX), 32'd1);
        apply(mk(2'd2, 2'd0, 2'd0, 1, 0, 0, 0, 4'd4, 1, 0, 32'h3, 32'h11, 32'h21));
        chk("stall_RW_EX", 32'(RW_EX), 32'd0);
        chk("stall_en_EX", 32'(enable_RF_EX), 32'd0);
        chk("stall_RW_MEM", 32'(RW_MEM), 32'd3);
        chk("stall_cnt", 32'(bubble_cnt), 32'd1);
        apply(mk(2'd2, 2'd0, 2'd0, 0, 1, 0, 0, 4'd4, 1, 0, 32'h3, 32'h11, 32'h21));
        chk("use_opA", opA_EX, 32'h3);
        chk("use_RW_WB", 32'(RW_WB), 32'd3);

        // Saturation at 15 after 20 stalls, then clear beating a stall.
        for (int i = 0; i < 20; i++)
            apply(mk(2'd0, 2'd0, 2'd0, 1, 1, 0, 0, 4'd0, 0, 0, 32'h0, 32'h0, 32'h0));
        chk("sat_cnt", 32'(bubble_cnt), 32'd15);
        apply(mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 4'd0, 0, 0, 32'h0, 32'h0, 32'h0));
        chk("clr_cnt", 32'(bubble_cnt), 32'd0);

        // Reset in the middle of a held stall with live traffic behind it.
        apply(mk(2'd0, 2'd0, 2'd0, 0, 1, 0, 0, 4'd6, 1, 1, 32'h1, 32'h11, 32'h21));
        apply(mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 4'd7, 1, 0, 32'h1, 32'h11, 32'h21));
        #2 RST_N = 1'b0;
        #1;
        check_all(z);
        #3 RST_N = 1'b1;
        #1;
        check_all(z);
        model_reset();
        apply(mk(2'd1, 2'd0, 2'd0, 0, 1, 0, 0, 4'd7, 1, 0, 32'h2, 32'h11, 32'h21));
        chk("post_rst_RW_EX", 32'(RW_EX), 32'd7);
        chk("post_rst_cnt", 32'(bubble_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
